// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite encodings and slave FSM states for the SRAM slave.
// Also holds the helper that maps a transfer size and address to SRAM byte lanes.
package ahb_lite_defs;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        SIZE_BYTE = 3'd0,
        SIZE_HALF = 3'd1,
        SIZE_WORD = 3'd2
    } hsize_t;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } hburst_t;

    localparam logic OKAY  = 1'b0;
    localparam logic ERROR = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } slave_state_t;

    // Little-endian lane enables; only called with sizes that passed the error check.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lo);
        case (size)
            SIZE_BYTE: lane_mask = 4'b0001 << lo;
            SIZE_HALF: lane_mask = lo[1] ? 4'b1100 : 4'b0011;
            default:   lane_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_sram_array.sv
// Byte-enabled MEM_BYTES/4 x 32 SRAM: synchronous write, combinational read.
// Same-cycle write data is forwarded per lane so a coincident read sees it.
module ahb_sram_array #(
    parameter int MEM_BYTES = 1024
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [3:0]                   wstrb,
    input  logic [$clog2(MEM_BYTES)-3:0] waddr,
    input  logic [31:0]                  wdata,
    input  logic [$clog2(MEM_BYTES)-3:0] raddr,
    output logic [31:0]                  rdata
);

    localparam int WORDS = MEM_BYTES / 4;

    logic [31:0] mem_q [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem_q[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rdata[gi*8 +: 8] = (we && wstrb[gi] && (waddr == raddr))
                                    ? wdata[gi*8 +: 8]
                                    : mem_q[raddr][gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with programmable wait states and ERROR responses.
// Define AHB_SRAM_SEQ_NOWAIT_EN to let SEQ beats skip the wait states.
module ahb_sram_slave
    import ahb_lite_defs::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_BYTES   = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [1:0]            HTRANS,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
);

    localparam int MEM_AW = $clog2(MEM_BYTES);
    localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    slave_state_t          state_q, state_d;
    logic [2:0]            wait_cnt_q, wait_cnt_d;
    logic [MEM_AW-1:0]     addr_q, addr_d;
    logic                  write_q, write_d;
    logic [2:0]            size_q, size_d;
    logic [2:0]            hburst_q, hburst_d;
    logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;

    logic        accept;
    logic        req_err;
    logic        skip_wait;
    logic        mem_we;
    logic [3:0]  mem_strb;
    logic [31:0] mem_rdata;

    // An address phase can only land while this slave is not stretching the bus.
    assign accept = HSEL && HREADY && HTRANS[1] &&
                    ((state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2));

    assign req_err = (HADDR >= ADDR_WIDTH'(MEM_BYTES))
                  || (HSIZE > 3'd2)
                  || ((HSIZE == SIZE_HALF) && HADDR[0])
                  || ((HSIZE == SIZE_WORD) && (HADDR[1:0] != 2'b00));

`ifdef AHB_SRAM_SEQ_NOWAIT_EN
    assign skip_wait = (WAIT_STATES == 0) || (HTRANS == SEQ);
`else
    assign skip_wait = (WAIT_STATES == 0);
`endif

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 3'd0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            size_q     <= 3'd0;
            hburst_q   <= 3'd0;
            hrdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            size_q     <= size_d;
            hburst_q   <= hburst_d;
            hrdata_q   <= hrdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        size_d     = size_q;
        hburst_d   = hburst_q;
        unique case (state_q)
            S_WAIT: begin
                if (wait_cnt_q == 3'd0) begin
                    state_d = S_DATA;
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    addr_d   = HADDR[MEM_AW-1:0];
                    write_d  = HWRITE && !req_err;
                    size_d   = HSIZE;
                    hburst_d = HBURST;
                    if (req_err) begin
                        state_d = S_ERR1;
                    end else if (skip_wait) begin
                        state_d = S_DATA;
                    end else begin
                        state_d    = S_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end
                end
            end
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = OKAY;
        mem_we    = 1'b0;
        hrdata_d  = hrdata_q;
        case (state_q)
            S_WAIT: HREADYOUT = 1'b0;
            S_DATA: begin
                mem_we = write_q;
                if (!write_q) begin
                    hrdata_d = mem_rdata;
                end
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = ERROR;
            end
            S_ERR2: HRESP = ERROR;
            default: ;
        endcase
    end

    // Read data is live in DATA and then held by hrdata_q until the next read.
    assign HRDATA   = hrdata_d;
    assign mem_strb = lane_mask(size_q, addr_q[1:0]);

    ahb_sram_array #(
        .MEM_BYTES (MEM_BYTES)
    ) u_array (
        .clk   (HCLK),
        .we    (mem_we),
        .wstrb (mem_strb),
        .waddr (addr_q[MEM_AW-1:2]),
        .wdata (HWDATA),
        .raddr (addr_q[MEM_AW-1:2]),
        .rdata (mem_rdata)
    );

    // Burst type is captured for observation; SEQ beats must keep it unchanged.
    seq_burst_stable: assert property (@(posedge HCLK) disable iff (HRESET)
        (accept && (HTRANS == SEQ)) |-> (HBURST == hburst_q));

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: transfer-level response/memory model plus directed checks.
// A second instance with three wait states covers reset in the middle of a wait.
module tb_ahb_sram_slave;

    localparam int WS   = 1;
    localparam int MEMB = 1024;

    logic HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic        HRESET, HSEL, HWRITE, HREADYOUT, HRESP;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [2:0]  HSIZE, HBURST;
    logic [1:0]  HTRANS;

    logic        r_rst, r_sel, r_write, r_ready, r_resp;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [2:0]  r_size, r_burst;
    logic [1:0]  r_trans;

    ahb_sram_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_BYTES(MEMB), .WAIT_STATES(WS)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HWDATA(HWDATA),
        .HREADY(HREADYOUT), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    ahb_sram_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_BYTES(MEMB), .WAIT_STATES(3)
    ) dut3 (
        .HCLK(HCLK), .HRESET(r_rst), .HSEL(r_sel), .HADDR(r_addr), .HWRITE(r_write),
        .HSIZE(r_size), .HBURST(r_burst), .HTRANS(r_trans), .HWDATA(r_wdata),
        .HREADY(r_ready), .HREADYOUT(r_ready), .HRESP(r_resp), .HRDATA(r_rdata)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    int low_cnt = 0;
    int resp_cnt = 0;
    logic [31:0] rd_log [$];
    logic [31:0] next_wdata = 32'h0;
    logic [2:0]  cur_burst = 3'd1;

    // Transfer-level model: byte memory plus the list of per-cycle responses owed.
    logic [7:0] mem_m [MEMB];
    bit         known [MEMB];
    typedef struct {
        bit rdy;
        bit resp;
        bit last;
        bit wr;
        int addr;
        int size;
    } exp_t;
    exp_t exp_q [$];

    always @(negedge HCLK) begin
        exp_t e;
        exp_t w;
        bit any_known;
        bit bad;
        bit [31:0] a;
        int sz;
        int nw;
        if (HRESET || !chk_en) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = '{rdy: 1'b1, resp: 1'b0, last: 1'b0, wr: 1'b0, addr: 0, size: 0};
            n_tests++;
            if (HREADYOUT !== e.rdy || HRESP !== e.resp) begin
                n_fail++;
                $display("FAIL ready_resp t=%0t: got ready=%b resp=%b, expected ready=%b resp=%b",
                         $time, HREADYOUT, HRESP, e.rdy, e.resp);
            end
            if (HREADYOUT === 1'b0) low_cnt++;
            if (HRESP === 1'b1) resp_cnt++;
            if (e.last) begin
                if (e.wr) begin
                    for (int b = 0; b < (1 << e.size); b++) begin
                        mem_m[e.addr + b] = HWDATA[((e.addr + b) % 4) * 8 +: 8];
                        known[e.addr + b] = 1'b1;
                    end
                end else begin
                    any_known = 1'b0;
                    bad = 1'b0;
                    for (int b = 0; b < (1 << e.size); b++) begin
                        if (known[e.addr + b]) begin
                            any_known = 1'b1;
                            if (HRDATA[((e.addr + b) % 4) * 8 +: 8] !== mem_m[e.addr + b]) bad = 1'b1;
                        end
                    end
                    rd_log.push_back(HRDATA);
                    if (any_known) begin
                        n_tests++;
                        if (bad) begin
                            n_fail++;
                            $display("FAIL rdata addr=%h size=%0d: got %h at t=%0t",
                                     e.addr, e.size, HRDATA, $time);
                        end
                    end
                end
            end
            if (e.rdy && HSEL === 1'b1 && HTRANS[1] === 1'b1) begin
                a  = HADDR;
                sz = int'(HSIZE);
                if (a >= MEMB || sz > 2 || (a % (1 << sz)) != 0) begin
                    exp_q.push_back('{rdy: 1'b0, resp: 1'b1, last: 1'b0, wr: 1'b0, addr: 0, size: 0});
                    exp_q.push_back('{rdy: 1'b1, resp: 1'b1, last: 1'b0, wr: 1'b0, addr: 0, size: 0});
                end else begin
                    nw = WS;
`ifdef AHB_SRAM_SEQ_NOWAIT_EN
                    if (HTRANS == 2'b11) nw = 0;
`endif
                    for (int k = 0; k < nw; k++)
                        exp_q.push_back('{rdy: 1'b0, resp: 1'b0, last: 1'b0, wr: 1'b0, addr: 0, size: 0});
                    w = '{rdy: 1'b1, resp: 1'b0, last: 1'b1, wr: HWRITE, addr: int'(a), size: sz};
                    exp_q.push_back(w);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] rdl(input int i);
        return (i < rd_log.size()) ? rd_log[i] : 32'hxxxxxxxx;
    endfunction

    // One address phase, held until the bus is ready; HWDATA carries the previous beat.
    task automatic issue(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                         input logic wr, input logic [2:0] sz, input logic [31:0] wd);
        bit done;
        HSEL = sel; HTRANS = tr; HADDR = a; HWRITE = wr; HSIZE = sz;
        HWDATA = next_wdata; HBURST = cur_burst;
        done = 1'b0;
        for (int i = 0; i < 16 && !done; i++) begin
            @(negedge HCLK);
            done = (HREADYOUT === 1'b1);
            @(posedge HCLK);
        end
        #1;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL hready_timeout: addr=%h never accepted, expected ready within 16 cycles", a);
        end
        next_wdata = wd;
    endtask

    task automatic idle();
        issue(1'b0, 2'b00, 32'h0, 1'b0, 3'd0, 32'h0);
    endtask

    task automatic d3_xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                           output logic [31:0] rd, output int waits);
        bit done;
        r_sel = 1'b1; r_trans = 2'b10; r_addr = a; r_write = wr; r_size = 3'd2;
        @(posedge HCLK); #1;
        r_sel = 1'b0; r_trans = 2'b00; r_wdata = wd;
        waits = 0; rd = '0; done = 1'b0;
        for (int i = 0; i < 16 && !done; i++) begin
            @(negedge HCLK);
            if (r_ready === 1'b1) begin
                rd = r_rdata;
                done = 1'b1;
            end else begin
                waits++;
            end
        end
        @(posedge HCLK); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int l0;
        int r0;
        int w;
        logic [31:0] rd;
        HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0; HWRITE = 1'b0;
        HSIZE = 3'd0; HBURST = 3'd1; HWDATA = '0;
        r_rst = 1'b1; r_sel = 1'b0; r_trans = 2'b00; r_addr = '0; r_write = 1'b0;
        r_size = 3'd0; r_burst = 3'd0; r_wdata = '0;
        repeat (2) @(posedge HCLK);
        #1;
        HRESET = 1'b0; r_rst = 1'b0;
        @(negedge HCLK);
        check("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check("rst_hresp", {31'd0, HRESP}, 32'd0);
        check("rst_hrdata", HRDATA, 32'h0);
        check("rst3_hreadyout", {31'd0, r_ready}, 32'd1);
        chk_en = 1'b1;
        @(posedge HCLK); #1;

        // Word write then read back
        rd_log.delete(); l0 = low_cnt;
        issue(1'b1, 2'b10, 32'h010, 1'b1, 3'd2, 32'hDEADBEEF);
        issue(1'b1, 2'b10, 32'h010, 1'b0, 3'd2, 32'h0);
        idle(); idle();
        check("word_rd", rdl(0), 32'hDEADBEEF);
        check("word_waits", 32'(low_cnt - l0), 32'd2);

        // Byte write into a known word
        rd_log.delete();
        issue(1'b1, 2'b10, 32'h020, 1'b1, 3'd2, 32'h11223344);
        issue(1'b1, 2'b10, 32'h022, 1'b1, 3'd0, 32'h00AA0000);
        issue(1'b1, 2'b10, 32'h020, 1'b0, 3'd2, 32'h0);
        idle(); idle();
        check("byte_merge", rdl(0), 32'h11AA3344);

        // Out-of-range read and misaligned halfword
        r0 = resp_cnt; l0 = low_cnt;
        issue(1'b1, 2'b10, 32'h400, 1'b0, 3'd2, 32'h0);
        idle(); idle();
        issue(1'b1, 2'b10, 32'h003, 1'b0, 3'd1, 32'h0);
        idle(); idle();
        check("err_resp_cycles", 32'(resp_cnt - r0), 32'd4);
        check("err_low_cycles", 32'(low_cnt - l0), 32'd2);

        // INCR4 with a BUSY after beat 2
        l0 = low_cnt; cur_burst = 3'd3;
        issue(1'b1, 2'b10, 32'h100, 1'b1, 3'd2, 32'h10000100);
        issue(1'b1, 2'b11, 32'h104, 1'b1, 3'd2, 32'h20000104);
        issue(1'b1, 2'b01, 32'h108, 1'b1, 3'd2, 32'h0);
        issue(1'b1, 2'b11, 32'h108, 1'b1, 3'd2, 32'h30000108);
        issue(1'b1, 2'b11, 32'h10C, 1'b1, 3'd2, 32'h4000010C);
        cur_burst = 3'd1;
        idle(); idle();
`ifdef AHB_SRAM_SEQ_NOWAIT_EN
        check("burst_waits", 32'(low_cnt - l0), 32'd1);
`else
        check("burst_waits", 32'(low_cnt - l0), 32'd4);
`endif
        rd_log.delete();
        for (int i = 0; i < 4; i++) issue(1'b1, 2'b10, 32'h100 + 32'(4 * i), 1'b0, 3'd2, 32'h0);
        idle(); idle();
        check("burst_rd0", rdl(0), 32'h10000100);
        check("burst_rd1", rdl(1), 32'h20000104);
        check("burst_rd2", rdl(2), 32'h30000108);
        check("burst_rd3", rdl(3), 32'h4000010C);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [1:0]  tr;
            logic [31:0] a;
            logic [2:0]  sz;
            r  = $urandom_range(0, 9);
            tr = (r < 5) ? 2'b10 : (r < 7) ? 2'b11 : (r < 8) ? 2'b01 : 2'b00;
            sz = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 63));
            if (sz <= 3'd2 && $urandom_range(0, 9) > 1) a = a & ~((32'd1 << sz) - 32'd1);
            if ($urandom_range(0, 19) == 0) a = 32'h400 + 32'($urandom_range(0, 4095));
            issue(1'($urandom_range(0, 7) != 0), tr, a, 1'($urandom_range(0, 1)), sz, $urandom);
        end
        idle(); idle(); idle();

        // Three-wait-state instance: reset on the second wait cycle drops the write
        d3_xfer(32'h040, 1'b1, 32'h12345678, rd, w);
        check("d3_wr_waits", 32'(w), 32'd3);
        d3_xfer(32'h040, 1'b0, 32'h0, rd, w);
        check("d3_rd_old", rd, 32'h12345678);
        check("d3_rd_waits", 32'(w), 32'd3);
        r_sel = 1'b1; r_trans = 2'b10; r_addr = 32'h040; r_write = 1'b1; r_size = 3'd2;
        @(posedge HCLK); #1;
        r_sel = 1'b0; r_trans = 2'b00; r_wdata = 32'hCAFEF00D;
        @(negedge HCLK);
        check("d3_wait1_low", {31'd0, r_ready}, 32'd0);
        @(posedge HCLK); #1;
        r_rst = 1'b1;
        @(negedge HCLK);
        check("d3_wait2_low", {31'd0, r_ready}, 32'd0);
        @(posedge HCLK); #1;
        r_rst = 1'b0;
        @(negedge HCLK);
        check("d3_rst_ready", {31'd0, r_ready}, 32'd1);
        check("d3_rst_resp", {31'd0, r_resp}, 32'd0);
        check("d3_rst_rdata", r_rdata, 32'h0);
        @(posedge HCLK); #1;
        d3_xfer(32'h040, 1'b0, 32'h0, rd, w);
        check("d3_rd_after_rst", rd, 32'h12345678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
